// File: rtl/keypad_scan_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_debounce_if
//  Purpose  : Keypad matrix pins plus the debounced key-code output.
//  Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_debounce_if;
    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;

    // master = the scanner (drives rows, reports keys); slave = keypad/consumer side
    modport master (
        output row,
        output key_code,
        output key_valid,
        input  column
    );

    modport slave (
        input  row,
        input  key_code,
        input  key_valid,
        output column
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_debounce
//  Purpose  : 4x4 keypad row scanner with press/release debounce; one
//             key_valid pulse per confirmed press.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_debounce #(
    parameter int SCAN_DIV    = 27000,
    parameter int DEB_SAMPLES = 8
) (
    input  wire                     clk,
    input  wire                     rst,
    keypad_scan_debounce_if.master  kp
);

    localparam int c_DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CW = $clog2(DEB_SAMPLES + 1);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(SCAN_DIV - 1);
    localparam logic [c_CW-1:0] c_DEB_LAST   = c_CW'(DEB_SAMPLES - 1);

    localparam logic [1:0] c_ST_SCAN     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_PRESSED  = 2'd2;
    localparam logic [1:0] c_ST_RELEASE  = 2'd3;

    logic [c_DW-1:0] r_dwell;
    logic [3:0]      r_col_meta;
    logic [3:0]      r_col_s;
    logic [1:0]      r_state;
    logic [3:0]      r_row;
    logic [3:0]      r_lat_col;
    logic [1:0]      r_lat_r;
    logic [1:0]      r_lat_c;
    logic [c_CW-1:0] r_deb_cnt;
    logic [3:0]      r_key_code;
    logic            r_key_valid;

    logic            w_sample;
    logic            w_hit;
    logic [1:0]      w_col_idx;
    logic [1:0]      w_row_idx;
    logic [3:0]      w_map_code;

    assign w_sample = (r_dwell == c_DWELL_LAST);
    assign w_hit    = (r_col_s != 4'hF);

    // Lowest-numbered low column wins when several are pressed
    always_comb begin
        w_col_idx = 2'd3;
        if (!r_col_s[0])      w_col_idx = 2'd0;
        else if (!r_col_s[1]) w_col_idx = 2'd1;
        else if (!r_col_s[2]) w_col_idx = 2'd2;
    end

    always_comb begin
        case (r_row)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            default: w_row_idx = 2'd3;
        endcase
    end

    always_comb begin
        case ({r_lat_r, r_lat_c})
            4'd0:    w_map_code = 4'h1;
            4'd1:    w_map_code = 4'h2;
            4'd2:    w_map_code = 4'h3;
            4'd3:    w_map_code = 4'hA;
            4'd4:    w_map_code = 4'h4;
            4'd5:    w_map_code = 4'h5;
            4'd6:    w_map_code = 4'h6;
            4'd7:    w_map_code = 4'hB;
            4'd8:    w_map_code = 4'h7;
            4'd9:    w_map_code = 4'h8;
            4'd10:   w_map_code = 4'h9;
            4'd11:   w_map_code = 4'hC;
            4'd12:   w_map_code = 4'hE;
            4'd13:   w_map_code = 4'h0;
            4'd14:   w_map_code = 4'hF;
            default: w_map_code = 4'hD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dwell     <= '0;
            r_col_meta  <= 4'hF;
            r_col_s     <= 4'hF;
            r_state     <= c_ST_SCAN;
            r_row       <= 4'b1110;
            r_lat_col   <= 4'hF;
            r_lat_r     <= 2'd0;
            r_lat_c     <= 2'd0;
            r_deb_cnt   <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_col_meta  <= kp.column;
            r_col_s     <= r_col_meta;
            r_dwell     <= w_sample ? '0 : r_dwell + c_DW'(1);
            r_key_valid <= 1'b0;

            case (r_state)
                c_ST_SCAN: begin
                    if (w_sample) begin
                        if (w_hit) begin
                            r_lat_col <= r_col_s;
                            r_lat_r   <= w_row_idx;
                            r_lat_c   <= w_col_idx;
                            r_deb_cnt <= '0;
                            r_state   <= c_ST_DEBOUNCE;
                        end else begin
                            r_row <= {r_row[2:0], r_row[3]};
                        end
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_sample) begin
                        if (r_col_s == r_lat_col) begin
                            // Code and pulse land together so the consumer sees the new code
                            if (r_deb_cnt == c_DEB_LAST) begin
                                r_state     <= c_ST_PRESSED;
                                r_key_valid <= 1'b1;
                                r_key_code  <= w_map_code;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + c_CW'(1);
                            end
                        end else begin
                            r_state <= c_ST_SCAN;
                            r_row   <= {r_row[2:0], r_row[3]};
                        end
                    end
                end
                c_ST_PRESSED: begin
                    r_state   <= c_ST_RELEASE;
                    r_deb_cnt <= '0;
                end
                default: begin
                    if (w_sample) begin
                        if (!w_hit) begin
                            if (r_deb_cnt == c_DEB_LAST) begin
                                r_state   <= c_ST_SCAN;
                                r_row     <= {r_row[2:0], r_row[3]};
                                r_deb_cnt <= '0;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + c_CW'(1);
                            end
                        end else begin
                            r_deb_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign kp.row       = r_row;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan_debounce
//  Purpose  : Keypad matrix model driving the scanner; per-dwell reference
//             model predicts rows, codes and pulse cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV    = 4;
    localparam int DEB_SAMPLES = 3;
    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_REL  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pressed = 16'h0;
    logic [3:0]  col_drv;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        prev_valid = 1'b0;

    int          exp_cyc_q[$];
    logic [3:0]  exp_code_q[$];

    int          m_row, m_mode, m_cnt, m_lat_r, m_lat_c;
    logic [3:0]  m_lat_col, m_code;
    logic [63:0] keymap_v;

    keypad_scan_debounce_if kp_if ();

    keypad_scan_debounce #(
        .SCAN_DIV    (SCAN_DIV),
        .DEB_SAMPLES (DEB_SAMPLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Passive switch matrix: a pressed key shorts its column to the strobed row
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp_if.row[r]) col_drv[c] = 1'b0;
    end
    assign kp_if.column = col_drv;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse: no key_valid at cyc=%0d, required code=%h", exp_cyc_q[0], exp_code_q[0]);
                void'(exp_cyc_q.pop_front());
                void'(exp_code_q.pop_front());
            end
            if (kp_if.key_valid === 1'b1) begin
                checks++;
                if (prev_valid) begin
                    failures++;
                    $display("FAIL pulse_width: key_valid high two cycles at cyc=%0d, required 1-cycle pulse", cyc);
                end else if (exp_cyc_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: key_valid at cyc=%0d code=%h, required no pulse", cyc, kp_if.key_code);
                end else begin
                    if (exp_cyc_q[0] != cyc || exp_code_q[0] !== kp_if.key_code) begin
                        failures++;
                        $display("FAIL pulse: got cyc=%0d code=%h, required cyc=%0d code=%h",
                                 cyc, kp_if.key_code, exp_cyc_q[0], exp_code_q[0]);
                    end
                    void'(exp_cyc_q.pop_front());
                    void'(exp_code_q.pop_front());
                end
            end else if (kp_if.key_valid !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL key_valid_level: got %b, required 0 or 1", kp_if.key_valid);
            end
            prev_valid = (kp_if.key_valid === 1'b1);
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b at cyc=%0d", name, got, req, cyc);
        end
    endtask

    // One debounce sample worth of behaviour, stated in terms of the keypad rules
    task automatic model_step(input logic [15:0] mask);
        logic [3:0] col;
        int         idx;
        col = 4'hF;
        idx = 0;
        for (int c = 0; c < 4; c++) if (mask[m_row*4+c]) col[c] = 1'b0;
        for (int c = 3; c >= 0; c--) if (!col[c]) idx = c;
        case (m_mode)
            M_SCAN: begin
                if (col == 4'hF) m_row = (m_row + 1) % 4;
                else begin
                    m_lat_col = col; m_lat_r = m_row; m_lat_c = idx;
                    m_cnt = 0; m_mode = M_DEB;
                end
            end
            M_DEB: begin
                if (col == m_lat_col) begin
                    m_cnt++;
                    if (m_cnt == DEB_SAMPLES) begin
                        m_code = keymap_v[(m_lat_r*4+m_lat_c)*4 +: 4];
                        exp_cyc_q.push_back(cyc);
                        exp_code_q.push_back(m_code);
                        m_mode = M_REL;
                        m_cnt = 0;
                    end
                end else begin
                    m_mode = M_SCAN;
                    m_row = (m_row + 1) % 4;
                end
            end
            default: begin
                if (col == 4'hF) begin
                    m_cnt++;
                    if (m_cnt == DEB_SAMPLES) begin
                        m_mode = M_SCAN;
                        m_row = (m_row + 1) % 4;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
        endcase
    endtask

    // Entered just after a sample edge (or the reset edge); leaves just after the next one
    task automatic step(input logic [15:0] mask);
        logic [3:0] exp_row;
        pressed = mask;
        repeat (2) @(posedge clk);
        #1;
        exp_row = ~(4'b0001 << m_row);
        check4("row", kp_if.row, exp_row);
        check4("key_code", kp_if.key_code, m_code);
        repeat (SCAN_DIV - 2) @(posedge clk);
        #1;
        model_step(mask);
    endtask

    task automatic run(input logic [15:0] mask, input int n);
        repeat (n) step(mask);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check4("reset_row", kp_if.row, 4'b1110);
        check4("reset_key_code", kp_if.key_code, 4'h0);
        check4("reset_key_valid", {3'b000, kp_if.key_valid}, 4'h0);
        exp_cyc_q.delete();
        exp_code_q.delete();
        m_row = 0; m_mode = M_SCAN; m_cnt = 0; m_code = 4'h0;
        m_lat_col = 4'hF; m_lat_r = 0; m_lat_c = 0;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        int          sel, len;
        keymap_v = 64'hDF0E_C987_B654_A321;
        pressed  = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run(16'h0, 10);                       // idle scan
        run(16'h0020, 20);                    // hold '5'
        run(16'h0, 8);
        mask = 16'h0001 << (m_row * 4);       // bounce on the row about to be sampled
        run(mask, 2);
        run(16'h0, 6);
        run(16'h8000, 20);                    // 'D'
        run(16'h0, 8);
        run(16'h0006, 20);                    // row0 col1+col2 -> '2'
        run(16'h0, 8);
        run(16'h0010, 15);                    // '4' then '6' on same row without release
        run(16'h0040, 15);
        run(16'h0, 8);

        repeat (25) begin
            sel = $urandom_range(0, 99);
            len = $urandom_range(1, 12);
            if (sel < 45)      mask = 16'h0;
            else if (sel < 85) mask = 16'h0001 << $urandom_range(0, 15);
            else               mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            run(mask, len);
        end

        run(16'h0, 12);
        mask = 16'h0004 << (m_row * 4);       // enter debounce, then reset mid-window
        run(mask, 2);
        do_reset();
        run(16'h0, 10);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, required 0", exp_cyc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
